usb_debug_dma: RTL and testbench
================================

# usb_debug_dma

USB debug DMA engine that moves data received from the USB interface into cart memory. It consumes the start/bank/address/length settings produced by the cart control register block and reports completion through its busy flag. It pops bytes from the USB RX byte FIFO, packs four bytes big-endian into one 32-bit word, and issues one memory bus write per word until the programmed length is exhausted.

## Interface

Parameters:
- none

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_reset  input  1  synchronous, active-high reset.
- i_dma_start  input  1  one-cycle start pulse from cart control.
- i_dma_bank  input  4  target memory bank, latched at start.
- i_dma_address  input  24  start address in 32-bit word units, latched at start.
- i_dma_length  input  20  transfer length in 32-bit words, latched at start.
- o_dma_busy  output  1  high while a transfer is in progress.
- i_dma_abort  input  1  abort request. Present only with USB_DEBUG_DMA_ABORT_EN.
- i_rx_empty  input  1  USB RX FIFO is empty.
- o_rx_read  output  1  pops one byte from the RX FIFO.
- i_rx_data  input  8  RX FIFO byte, valid the cycle after o_rx_read.
- o_mem_request  output  1  memory write request, held until accepted.
- o_mem_write  output  1  always 1 while o_mem_request is high.
- i_mem_busy  input  1  memory bus stall; a request is accepted on a cycle with o_mem_request && !i_mem_busy.
- o_mem_bank  output  4  latched bank.
- o_mem_address  output  24  word address of the current write.
- o_mem_data  output  32  packed word (first byte received in bits [31:24]).

## Operation

- States: IDLE, FILL, WRITE.
- IDLE:
  - On i_dma_start with i_dma_length != 0: latch bank, address and length; clear the byte counter; go to FILL.
  - On i_dma_start with length 0: ignored; o_dma_busy stays 0.
  - i_dma_start is ignored in every state other than IDLE.
- FILL:
  - Assert o_rx_read on any cycle where !i_rx_empty and the number of bytes issued (read strobes sent for the current word) is below 4.
  - One read is in flight per cycle at most; back-to-back pops are allowed.
  - Each returned byte shifts into the packing register MSB-first.
  - When the 4th byte is captured, go to WRITE; o_rx_read is low for that cycle.
- WRITE:
  - Hold o_mem_request=1 with stable bank, address and data until accepted.
  - On acceptance, increment the address (24-bit wrap, FF_FFFF→00_0000) and decrement the remaining length.
  - If the remaining length becomes 0, go to IDLE; otherwise clear the byte counter and go to FILL.
  - No RX reads occur during WRITE.
- Output derivation: o_dma_busy = (state != IDLE). o_mem_write mirrors o_mem_request.
- RX FIFO empty mid-word: wait in FILL indefinitely; the partial word is retained.
- Reset at any time, including mid-transfer:
  - All state returns to IDLE; partial bytes are discarded.
  - Outputs go low (o_mem_request=0, o_rx_read=0, o_dma_busy=0); address, bank and data registers are cleared to 0.
  - Bytes already popped are lost.

## Timing

- o_dma_busy rises the cycle after the accepted i_dma_start.
- Earliest first o_rx_read: the cycle after start (FILL entry).
- Byte latency: data is captured the cycle after its o_rx_read.
- Word latency with no stalls:
  - 4 read cycles, then 1 capture cycle; o_mem_request rises the cycle after the 4th byte is captured.
  - Accepted the same cycle if i_mem_busy=0.
  - Next FILL begins the following cycle. Best-case throughput is therefore one word per 6 cycles.
- o_dma_busy falls the cycle after the last write is accepted.
- o_mem_request never drops without acceptance, except on reset or abort.

## Configuration

- USB_DEBUG_DMA_ABORT_EN defined:
  - i_dma_abort exists. When high in any state, it forces IDLE the next cycle.
  - It drops o_mem_request and discards partial bytes.
  - A byte in flight from a final o_rx_read is ignored.
  - Abort takes priority over i_dma_start in the same cycle.
- Not defined: no port; a transfer runs until length is exhausted or reset.

## Test plan

- Start, bank 1, address 0x00_0010, length 2; FIFO holds 01..08, no stall → writes 0x01020304 @0x000010 then 0x05060708 @0x000011, bank 1; busy low afterwards.
- Start with length 0 → o_dma_busy stays 0; no o_rx_read, no o_mem_request.
- Address 0xFF_FFFF, length 2 → second write at 0x00_0000.
- FIFO empty after 2 bytes for 10 cycles, i_mem_busy high 5 cycles during WRITE → no extra reads, request held stable, correct word written once.
- Second i_dma_start mid-transfer → ignored; remaining count unaffected.
- Reset asserted during WRITE (and, with USB_DEBUG_DMA_ABORT_EN, abort during FILL) → next cycle IDLE, request low, busy low; a fresh start packs from byte 0.

Source files
------------

// File: rtl/usb_debug_dma.sv
// ============================================================================
// usb_debug_dma : USB RX FIFO -> cart memory DMA, big-endian 4-byte packing.
// Optional abort input via USB_DEBUG_DMA_ABORT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module usb_debug_dma (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dma_start,
  input  logic [3:0]  i_dma_bank,
  input  logic [23:0] i_dma_address,
  input  logic [19:0] i_dma_length,
  output logic        o_dma_busy,
`ifdef USB_DEBUG_DMA_ABORT_EN
  input  logic        i_dma_abort,
`endif
  input  logic        i_rx_empty,
  output logic        o_rx_read,
  input  logic [7:0]  i_rx_data,
  output logic        o_mem_request,
  output logic        o_mem_write,
  input  logic        i_mem_busy,
  output logic [3:0]  o_mem_bank,
  output logic [23:0] o_mem_address,
  output logic [31:0] o_mem_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  bank;
  logic [23:0] address;
  logic [19:0] length;
  logic [31:0] data;
  logic [2:0]  issued;
  logic [1:0]  captured;
  logic        rd_pending;
  logic        abort;
  logic        start_ok;

`ifdef USB_DEBUG_DMA_ABORT_EN
  assign abort = i_dma_abort;
`else
  assign abort = 1'b0;
`endif

  assign start_ok = i_dma_start && (i_dma_length != 20'd0) && !abort;

  always_comb begin
    state_next    = state;
    o_rx_read     = 1'b0;
    o_mem_request = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = FILL;
      end
      FILL: begin
        // issued runs ahead of captured, so the 4th-capture cycle never reads
        o_rx_read = !i_rx_empty && (issued < 3'd4);
        if (rd_pending && (captured == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        o_mem_request = 1'b1;
        if (!i_mem_busy) state_next = (length == 20'd1) ? IDLE : FILL;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      bank       <= 4'd0;
      address    <= 24'd0;
      length     <= 20'd0;
      data       <= 32'd0;
      issued     <= 3'd0;
      captured   <= 2'd0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      rd_pending <= o_rx_read;
      case (state)
        IDLE: begin
          if (start_ok) begin
            bank     <= i_dma_bank;
            address  <= i_dma_address;
            length   <= i_dma_length;
            issued   <= 3'd0;
            captured <= 2'd0;
          end
        end
        FILL: begin
          if (o_rx_read) issued <= issued + 3'd1;
          if (rd_pending) begin
            data     <= {data[23:0], i_rx_data};
            captured <= captured + 2'd1;
          end
        end
        WRITE: begin
          if (!i_mem_busy) begin
            address  <= address + 24'd1;
            length   <= length - 20'd1;
            issued   <= 3'd0;
            captured <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dma_busy    = (state != IDLE);
  assign o_mem_write   = o_mem_request;
  assign o_mem_bank    = bank;
  assign o_mem_address = address;
  assign o_mem_data    = data;

endmodule

`default_nettype wire

// File: tb/tb_usb_debug_dma.sv
// ============================================================================
// tb_usb_debug_dma : scoreboard bench for usb_debug_dma.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_usb_debug_dma;

  logic        clk;
  logic        rst;
  logic        dma_start;
  logic [3:0]  dma_bank;
  logic [23:0] dma_address;
  logic [19:0] dma_length;
  logic        dma_busy;
  logic        dma_abort;
  logic        rx_empty;
  logic        rx_read;
  logic [7:0]  rx_data;
  logic        mem_request;
  logic        mem_write;
  logic        mem_busy;
  logic [3:0]  mem_bank;
  logic [23:0] mem_address;
  logic [31:0] mem_data;

  typedef struct packed {
    logic [3:0]  bank;
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0] fifo_mem [0:255];
  int         wr_cnt = 0;
  int         rd_ptr = 0;

  usb_debug_dma dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_dma_start   (dma_start),
    .i_dma_bank    (dma_bank),
    .i_dma_address (dma_address),
    .i_dma_length  (dma_length),
    .o_dma_busy    (dma_busy),
`ifdef USB_DEBUG_DMA_ABORT_EN
    .i_dma_abort   (dma_abort),
`endif
    .i_rx_empty    (rx_empty),
    .o_rx_read     (rx_read),
    .i_rx_data     (rx_data),
    .o_mem_request (mem_request),
    .o_mem_write   (mem_write),
    .i_mem_busy    (mem_busy),
    .o_mem_bank    (mem_bank),
    .o_mem_address (mem_address),
    .o_mem_data    (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // RX FIFO model: byte appears on rx_data the cycle after the pop
  assign rx_empty = (rd_ptr >= wr_cnt);
  always @(posedge clk) begin
    if (rx_read && (rd_ptr < wr_cnt)) begin
      rx_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write
  logic held;
  wr_t  held_val;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (rx_read) check("rx_read_not_empty", {63'd0, rx_empty}, 64'd0);
      if (mem_request) begin
        check("mem_write_level", {63'd0, mem_write}, 64'd1);
        if (held) check("request_stable", {4'd0, mem_bank, mem_address, mem_data}, {4'd0, held_val});
        if (!mem_busy) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_write", {4'd0, mem_bank, mem_address, mem_data}, 64'd0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("mem_word", {4'd0, mem_bank, mem_address, mem_data}, {4'd0, e});
          end
        end else begin
          held     = 1'b1;
          held_val = {mem_bank, mem_address, mem_data};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_cnt[7:0]] = b;
    wr_cnt++;
  endtask

  task automatic expect_word(input logic [3:0] b, input logic [23:0] a, input logic [31:0] d);
    wr_t e;
    e.bank = b;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_dma(input logic [3:0] b, input logic [23:0] a, input logic [19:0] len);
    dma_bank    = b;
    dma_address = a;
    dma_length  = len;
    dma_start   = 1'b1;
    @(negedge clk);
    dma_start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (dma_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {63'd0, dma_busy}, 64'd0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!mem_request && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_request", {63'd0, mem_request}, 64'd1);
  endtask

  initial begin
    int cyc;
    int base;
    rst = 1'b1; dma_start = 1'b0; dma_bank = 4'd0; dma_address = 24'd0;
    dma_length = 20'd0; dma_abort = 1'b0; mem_busy = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_busy", {63'd0, dma_busy}, 64'd0);
    check("reset_request", {63'd0, mem_request}, 64'd0);
    check("reset_rx_read", {63'd0, rx_read}, 64'd0);
    check("reset_bank_addr", {36'd0, mem_bank, mem_address}, 64'd0);
    check("reset_data", {32'd0, mem_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two words, no stall, plus an ignored start mid-transfer
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    expect_word(4'd1, 24'h000010, 32'h01020304);
    expect_word(4'd1, 24'h000011, 32'h05060708);
    start_dma(4'd1, 24'h000010, 20'd2);
    check("busy_after_start", {63'd0, dma_busy}, 64'd1);
    cyc = 1;
    while (!mem_request && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("first_request_latency", 64'(cyc), 64'd6);
    @(negedge clk);
    start_dma(4'd7, 24'h000300, 20'd5);
    wait_idle(100);
    check("t1_reads", 64'(rd_ptr), 64'd8);
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    // Zero length start is ignored
    start_dma(4'd2, 24'h000050, 20'd0);
    for (int i = 0; i < 5; i++) begin
      check("len0_quiet", {61'd0, dma_busy, rx_read, mem_request}, 64'd0);
      @(negedge clk);
    end

    // Address wrap
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    expect_word(4'd3, 24'hFFFFFF, 32'h10111213);
    expect_word(4'd3, 24'h000000, 32'h14151617);
    start_dma(4'd3, 24'hFFFFFF, 20'd2);
    wait_idle(100);
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // FIFO underrun mid-word then memory stall
    base = rd_ptr;
    push_byte(8'hA1); push_byte(8'hA2);
    expect_word(4'd4, 24'h000200, 32'hA1A2A3A4);
    start_dma(4'd4, 24'h000200, 20'd1);
    repeat (10) @(negedge clk);
    check("underrun_reads", 64'(rd_ptr - base), 64'd2);
    check("underrun_busy", {63'd0, dma_busy}, 64'd1);
    mem_busy = 1'b1;
    push_byte(8'hA3); push_byte(8'hA4);
    wait_req(20);
    repeat (5) @(negedge clk);
    check("stall_request_held", {63'd0, mem_request}, 64'd1);
    mem_busy = 1'b0;
    wait_idle(20);
    check("t4_reads", 64'(rd_ptr - base), 64'd4);

    // Reset during WRITE, then a fresh transfer packs from byte 0
    push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3); push_byte(8'hB4);
    mem_busy = 1'b1;
    start_dma(4'd5, 24'h000040, 20'd1);
    wait_req(20);
    rst = 1'b1;
    @(negedge clk);
    check("rst_write_quiet", {62'd0, dma_busy, mem_request}, 64'd0);
    check("rst_write_regs", {36'd0, mem_bank, mem_address}, 64'd0);
    rst = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    expect_word(4'd6, 24'h000080, 32'hC1C2C3C4);
    start_dma(4'd6, 24'h000080, 20'd1);
    wait_idle(50);

`ifdef USB_DEBUG_DMA_ABORT_EN
    // Abort mid-FILL discards the partial word
    push_byte(8'hD1); push_byte(8'hD2);
    start_dma(4'd8, 24'h000090, 20'd3);
    repeat (4) @(negedge clk);
    dma_abort = 1'b1;
    @(negedge clk);
    dma_abort = 1'b0;
    check("abort_quiet", {62'd0, dma_busy, mem_request}, 64'd0);
    push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3); push_byte(8'hE4);
    expect_word(4'd9, 24'h0000A0, 32'hE1E2E3E4);
    start_dma(4'd9, 24'h0000A0, 20'd1);
    wait_idle(50);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
